// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the multi-cycle MIPS datapath.
// Picks the next PC from five sources and evaluates BEQ/BNE/BLEZ/BGTZ
// branch conditions. A two-state RUN/TRAP machine handles precise
// exception entry. External requests and misaligned targets save the
// current PC in epc, record the cause, and vector to EXC_VECTOR.
// ERET returns to the saved epc.
module pc_unit #(
    parameter int             N            = 32,
    parameter logic [N-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [N-1:0]   EXC_VECTOR   = 32'h0000_0080,
    parameter bit             ALIGN_CHECK  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pc_write,
    input  logic         pc_write_cond,
    input  logic [1:0]   br_cond,
    input  logic         zero_flag,
    input  logic         neg_flag,
    input  logic [2:0]   pc_src,
    input  logic [N-1:0] alu_result,
    input  logic [N-1:0] alu_out,
    input  logic [N-1:0] jump_address,
    input  logic [N-1:0] reg_target,
    input  logic         exc_req,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] epc,
    output logic [1:0]   cause,
    output logic         trap
);

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BLEZ = 2'b10;
    localparam logic [1:0] BR_BGTZ = 2'b11;

    localparam logic [2:0] SRC_ALU_RESULT = 3'b000;
    localparam logic [2:0] SRC_ALU_OUT    = 3'b001;
    localparam logic [2:0] SRC_JUMP       = 3'b010;
    localparam logic [2:0] SRC_REG        = 3'b011;
    localparam logic [2:0] SRC_ERET       = 3'b100;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_EXTERNAL = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic         cond_true;
    logic         take;
    logic         src_valid;
    logic [N-1:0] target;
    logic         misaligned;
    logic         do_update;
    logic         trap_misalign;

    // Branch condition from the ALU flags, selected by the branch type
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            BR_BEQ:  cond_true = zero_flag;
            BR_BNE:  cond_true = ~zero_flag;
            BR_BLEZ: cond_true = zero_flag | neg_flag;
            BR_BGTZ: cond_true = ~zero_flag & ~neg_flag;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-PC source mux; reserved codes are flagged so they never update or trap
    always_comb begin
        target    = '0;
        src_valid = 1'b1;
        case (pc_src)
            SRC_ALU_RESULT: target = alu_result;
            SRC_ALU_OUT:    target = alu_out;
            SRC_JUMP:       target = jump_address;
            SRC_REG:        target = reg_target;
            SRC_ERET:       target = epc;
            default: begin
                target    = '0;
                src_valid = 1'b0;
            end
        endcase
    end

    assign take          = pc_write | (pc_write_cond & cond_true);
    assign misaligned    = ALIGN_CHECK && (target[1:0] != 2'b00);
    assign do_update     = take & src_valid;
    assign trap_misalign = do_update & misaligned;

    // State register, forced back to RUN by reset from any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Enter TRAP on an external request or misaligned target; TRAP lasts one cycle
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (exc_req || trap_misalign) begin
                    next_state = TRAP;
                end
            end
            TRAP:    next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Trap indicator is a pure function of the state
    always_comb begin
        trap = 1'b0;
        if (state == TRAP) begin
            trap = 1'b1;
        end
    end

    // PC, EPC and cause registers; external requests outrank any PC update in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out <= RESET_VECTOR;
            epc    <= '0;
            cause  <= CAUSE_NONE;
        end else if (state == TRAP) begin
            pc_out <= EXC_VECTOR;
        end else if (exc_req) begin
            epc    <= pc_out;
            cause  <= CAUSE_EXTERNAL;
        end else if (trap_misalign) begin
            epc    <= pc_out;
            cause  <= CAUSE_MISALIGN;
        end else if (do_update) begin
            pc_out <= target;
            if (pc_src == SRC_ERET) begin
                cause <= CAUSE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed bench for pc_unit.
// A behavioural model is compared against the DUT on every falling edge.
// Literal checks pin down the model at key points.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  br_cond;
    logic        zero_flag;
    logic        neg_flag;
    logic [2:0]  pc_src;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] jump_address;
    logic [31:0] reg_target;
    logic        exc_req;
    logic [31:0] pc_out;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        trap;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    logic        m_in_trap;

    pc_unit #(
        .N            (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0080),
        .ALIGN_CHECK  (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .br_cond       (br_cond),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .pc_src        (pc_src),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .jump_address  (jump_address),
        .reg_target    (reg_target),
        .exc_req       (exc_req),
        .pc_out        (pc_out),
        .epc           (epc),
        .cause         (cause),
        .trap          (trap)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: the ALU result is classified as zero, negative or
    // positive. Each branch type is then the matching signed comparison
    // against zero.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc      = 32'h0;
            m_epc     = 32'h0;
            m_cause   = 2'd0;
            m_in_trap = 1'b0;
        end else if (m_in_trap) begin
            m_pc      = 32'h80;
            m_in_trap = 1'b0;
        end else if (exc_req) begin
            m_epc     = m_pc;
            m_cause   = 2'd2;
            m_in_trap = 1'b1;
        end else begin
            int          sgn;
            bit          branch_ok;
            bit          go;
            logic [31:0] cand [5];
            sgn = zero_flag ? 0 : (neg_flag ? -1 : 1);
            case (br_cond)
                2'd0:    branch_ok = (sgn == 0);
                2'd1:    branch_ok = (sgn != 0);
                2'd2:    branch_ok = (sgn <= 0);
                default: branch_ok = (sgn > 0);
            endcase
            go = pc_write || (pc_write_cond && branch_ok);
            cand[0] = alu_result;
            cand[1] = alu_out;
            cand[2] = jump_address;
            cand[3] = reg_target;
            cand[4] = m_epc;
            if (go && pc_src < 3'd5) begin
                if ((cand[pc_src] % 4) != 0) begin
                    m_epc     = m_pc;
                    m_cause   = 2'd1;
                    m_in_trap = 1'b1;
                end else begin
                    m_pc = cand[pc_src];
                    if (pc_src == 3'd4) m_cause = 2'd0;
                end
            end
        end
    end

    // Compare process: every falling edge, DUT against model
    always @(negedge clk) begin
        tests_run++;
        if (pc_out !== m_pc) begin
            tests_failed++;
            $display("[TB] FAIL model_pc t=%0t got %h expected %h", $time, pc_out, m_pc);
        end
        tests_run++;
        if (epc !== m_epc) begin
            tests_failed++;
            $display("[TB] FAIL model_epc t=%0t got %h expected %h", $time, epc, m_epc);
        end
        tests_run++;
        if (cause !== m_cause) begin
            tests_failed++;
            $display("[TB] FAIL model_cause t=%0t got %0d expected %0d", $time, cause, m_cause);
        end
        tests_run++;
        if (trap !== m_in_trap) begin
            tests_failed++;
            $display("[TB] FAIL model_trap t=%0t got %0d expected %0d", $time, trap, m_in_trap);
        end
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance past the next rising edge
    task automatic applyStimulus(
        input logic        pw,
        input logic        pwc,
        input logic [1:0]  bc,
        input logic        z,
        input logic        n,
        input logic [2:0]  src,
        input logic [31:0] val,
        input logic        exc
    );
        pc_write      = pw;
        pc_write_cond = pwc;
        br_cond       = bc;
        zero_flag     = z;
        neg_flag      = n;
        pc_src        = src;
        alu_result    = (src == 3'd0) ? val : 32'h0;
        alu_out       = (src == 3'd1) ? val : 32'h0;
        jump_address  = (src == 3'd2 || src >= 3'd5) ? val : 32'h0;
        reg_target    = (src == 3'd3) ? val : 32'h0;
        exc_req       = exc;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    endtask

    task automatic loadPc(input logic [31:0] value);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, value, 1'b0);
    endtask

    initial begin
        bit          br_expect [4][3];
        logic        zn_z [3];
        logic        zn_n [3];
        logic [31:0] exp_pc;

        // Rows: BEQ, BNE, BLEZ, BGTZ. Columns: (z,n) = (1,0), (0,1), (0,0)
        br_expect = '{'{1, 0, 0}, '{0, 1, 1}, '{1, 1, 0}, '{0, 0, 1}};
        zn_z = '{1'b1, 1'b0, 1'b0};
        zn_n = '{1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        pc_write = 1'b0; pc_write_cond = 1'b0; br_cond = 2'd0;
        zero_flag = 1'b0; neg_flag = 1'b0; pc_src = 3'd0;
        alu_result = 32'h0; alu_out = 32'h0; jump_address = 32'h0;
        reg_target = 32'h0; exc_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        checkOutput("reset_pc", pc_out, 32'h0);
        checkOutput("reset_epc", epc, 32'h0);
        checkOutput("reset_cause", {30'h0, cause}, 32'h0);
        checkOutput("reset_trap", {31'h0, trap}, 32'h0);

        // Sequential PC+4 updates
        loadPc(32'h4);
        checkOutput("seq_pc4", pc_out, 32'h4);
        loadPc(32'h8);
        checkOutput("seq_pc8", pc_out, 32'h8);
        loadPc(32'hC);
        checkOutput("seq_pcC", pc_out, 32'hC);
        checkOutput("seq_trap", {31'h0, trap}, 32'h0);

        // Conditional branches from 0x10 to 0x40
        loadPc(32'h10);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b0, 1'b1, 2'(b), zn_z[k], zn_n[k], 3'd1, 32'h40, 1'b0);
                exp_pc = br_expect[b][k] ? 32'h40 : 32'h10;
                checkOutput($sformatf("branch_bc%0d_zn%0d", b, k), pc_out, exp_pc);
                loadPc(32'h10);
            end
        end

        // Misaligned register target traps
        loadPc(32'h20);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd3, 32'h102, 1'b0);
        checkOutput("mis_trap", {31'h0, trap}, 32'h1);
        checkOutput("mis_epc", epc, 32'h20);
        checkOutput("mis_cause", {30'h0, cause}, 32'h1);
        checkOutput("mis_pc_held", pc_out, 32'h20);
        // Inputs during TRAP must be ignored
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 32'h300, 1'b1);
        checkOutput("mis_vector", pc_out, 32'h80);
        checkOutput("mis_trap_end", {31'h0, trap}, 32'h0);
        checkOutput("mis_cause_kept", {30'h0, cause}, 32'h1);

        // External exception beats a simultaneous jump
        loadPc(32'h30);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 32'h200, 1'b1);
        checkOutput("ext_trap", {31'h0, trap}, 32'h1);
        checkOutput("ext_epc", epc, 32'h30);
        checkOutput("ext_cause", {30'h0, cause}, 32'h2);
        checkOutput("ext_pc_held", pc_out, 32'h30);
        idleCycle();
        checkOutput("ext_vector", pc_out, 32'h80);

        // ERET, then reserved source code
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 32'h0, 1'b0);
        checkOutput("eret_pc", pc_out, 32'h30);
        checkOutput("eret_cause", {30'h0, cause}, 32'h0);
        checkOutput("eret_epc", epc, 32'h30);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd5, 32'h400, 1'b0);
        checkOutput("reserved_pc", pc_out, 32'h30);
        checkOutput("reserved_trap", {31'h0, trap}, 32'h0);

        // All-ones aligned target is legal
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 32'hFFFF_FFFC, 1'b0);
        checkOutput("max_target", pc_out, 32'hFFFF_FFFC);

        // Reset during TRAP
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
        checkOutput("rst_pre_trap", {31'h0, trap}, 32'h1);
        exc_req = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_pc", pc_out, 32'h0);
        checkOutput("rst_async_epc", epc, 32'h0);
        checkOutput("rst_async_cause", {30'h0, cause}, 32'h0);
        checkOutput("rst_async_trap", {31'h0, trap}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_no_trap%0d", i), {31'h0, trap}, 32'h0);
            checkOutput($sformatf("rst_pc_hold%0d", i), pc_out, 32'h0);
            idleCycle();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the multi-cycle MIPS datapath, the successor to the basic PC register. Selects among five next-PC sources. Evaluates four branch conditions (BEQ/BNE/BLEZ/BGTZ) instead of zero-only. Adds precise exception entry: a small FSM traps on external exception requests and misaligned targets, captures EPC/cause, vectors to a handler, and supports ERET.

Parameters:
N, 32, datapath/address width in bits
RESET_VECTOR, 32'h0000_0000, pc_out value after reset
EXC_VECTOR, 32'h0000_0080, handler address loaded on trap
ALIGN_CHECK, 1, 1 = trap on target with target[1:0] != 0; 0 = no alignment checking

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc_write  input  1  unconditional PC update enable
pc_write_cond  input  1  conditional (branch) update enable
br_cond  input  2  00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ
zero_flag  input  1  ALU result == 0
neg_flag  input  1  ALU result sign bit
pc_src  input  3  000 alu_result, 001 alu_out, 010 jump_address, 011 reg_target, 100 epc (ERET), 101-111 reserved
alu_result  input  N  PC+4 from ALU
alu_out  input  N  registered branch target
jump_address  input  N  J/JAL target
reg_target  input  N  JR/JALR register target
exc_req  input  1  external exception request (overflow, illegal opcode)
pc_out  output  N  current PC
epc  output  N  exception PC
cause  output  2  00 none, 01 misaligned target, 10 external
trap  output  1  high during the TRAP state cycle

Behaviour:
- Reset (async, any state): pc_out=RESET_VECTOR, epc=0, cause=00, trap=0, FSM=RUN.
- cond_true: BEQ=zero_flag; BNE=~zero_flag; BLEZ=zero_flag|neg_flag; BGTZ=~zero_flag&~neg_flag.
- take = pc_write | (pc_write_cond & cond_true).
- target = mux(pc_src); reserved codes: take has no effect, no trap.
- FSM states: RUN, TRAP.
- RUN, priority highest first:
  1. exc_req=1: epc<=pc_out; cause<=10; pc_out held; next=TRAP. Any take in the same cycle is discarded.
  2. take & valid pc_src & ALIGN_CHECK & target[1:0]!=0: epc<=pc_out; cause<=01; pc_out held; next=TRAP.
  3. take & valid pc_src: pc_out<=target on the next edge (1-cycle latency).
  4. Otherwise: hold all registers.
- TRAP: lasts exactly 1 cycle; trap=1 (Moore output). pc_out<=EXC_VECTOR; next=RUN. All inputs, including exc_req, are ignored in this cycle.
- ERET (pc_src=100 with take): pc_out<=epc; cause<=00; epc unchanged. A misaligned epc still traps when ALIGN_CHECK=1.
- Arithmetic: none internal. Targets are used as given, N-bit, with no wrap or overflow detection. A target of all-ones is legal if aligned.
- epc and cause change only on trap entry (and cause clears on ERET).
- Reset asserted during TRAP returns to RUN at RESET_VECTOR with no trap pulse after release.

Test Plan:
- Reset release, pc_src=000, pc_write=1, alu_result=0x4 for 3 cycles (alu_result incremented by 4 each cycle) -> pc_out 0x0, 0x4, 0x8, 0xC; trap=0.
- pc_out=0x10, pc_write_cond=1, alu_out=0x40, each br_cond with (zero,neg) in {(1,0),(0,1),(0,0)} -> update only when cond_true (e.g. BGTZ only for (0,0); BLEZ for (1,0),(0,1)).
- pc_out=0x20, pc_write=1, pc_src=011, reg_target=0x102 -> trap=1 next cycle, epc=0x20, cause=01, then pc_out=0x80.
- pc_out=0x30, exc_req=1 together with pc_write=1, jump_address=0x200 -> jump ignored; epc=0x30, cause=10, pc_out=0x80 after TRAP.
- After the previous case, pc_write=1, pc_src=100 -> pc_out=0x30, cause=00; pc_src=101 with pc_write=1 -> pc_out unchanged.
- Assert reset while trap=1 -> pc_out=RESET_VECTOR immediately, epc=0, cause=00, no further trap pulse.
